sonar_distance_filter: RTL
==========================

SONAR_DISTANCE_FILTER -- requirements
Module: sonar_distance_filter

Interface
REQ-001 SHALL have parameter MIN_CM, default 2, meaning smallest accepted distance (cm, inclusive).
REQ-002 SHALL have parameter MAX_CM, default 399, meaning largest accepted distance (cm, inclusive).
REQ-003 SHALL have parameter DEFAULT_CM, default 25, meaning distance_out value after reset.
REQ-004 SHALL have parameter NEAR_CM, default 20, meaning near-obstacle assert threshold (cm).
REQ-005 SHALL have parameter HYST_CM, default 5, meaning near-obstacle release margin (cm).
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 12_500_000, meaning clocks without an accepted sample before stale (100 ms at 125 MHz).
REQ-007 SHALL have port clk_125mhz  input  1  system clock, all logic on rising edge.
REQ-008 SHALL have port reset_n  input  1  synchronous active-low reset.
REQ-009 SHALL have port distance_cm  input  16  raw sensor distance, sampled only when measurement_ready=1.
REQ-010 SHALL have port measurement_ready  input  1  single-cycle strobe, synchronous to clk_125mhz.
REQ-011 SHALL have port distance_out  output  16  filtered distance (cm) for display and motor control.
REQ-012 SHALL have port valid_out  output  1  one-cycle strobe when distance_out updates.
REQ-013 SHALL have port obstacle_near  output  1  hysteretic near-obstacle flag.
REQ-014 SHALL have port stale  output  1  no accepted sample within TIMEOUT_CYCLES.
REQ-015 SHALL have port reject_count  output  8  saturating count of rejected samples.

Function
REQ-016 Sample SHALL be accepted iff measurement_ready=1 and MIN_CM <= distance_cm <= MAX_CM (unsigned compare); otherwise it SHALL be rejected.
REQ-017 Rejected sample SHALL leave window, distance_out, valid_out and stale counter untouched; reject_count SHALL increment, saturating at 255.
REQ-018 Fill FSM states: EMPTY -> ONE -> TWO -> FULL, advancing one state per accepted sample; FULL SHALL remain FULL.
REQ-019 Window SHALL be a 3-entry shift register, newest at entry 0, shifted on each accept.
REQ-020 Filtered value: ONE = newest sample; TWO = min of two samples (conservative); FULL = median of three.
REQ-021 Pipeline SHALL be two stages: cycle N accept/shift, cycle N+1 compute and register distance_out with valid_out=1 for exactly that cycle.
REQ-022 Back-to-back strobes on consecutive cycles SHALL each be accepted; throughput one sample per cycle.
REQ-023 obstacle_near SHALL set when registered distance_out < NEAR_CM, clear when distance_out >= NEAR_CM+HYST_CM, else hold; evaluated on valid_out cycles.
REQ-024 Stale counter SHALL clear on every accepted sample, otherwise increment saturating; stale=1 when count reaches TIMEOUT_CYCLES-1.
REQ-025 stale=1 SHALL force obstacle_near=1; stale SHALL clear on cycle after next accepted sample.
REQ-026 Accept coinciding with counter reaching terminal count: accept SHALL win, stale stays 0.

Reset
REQ-027 reset_n=0 at a rising edge SHALL set FSM EMPTY, window zeros, distance_out=DEFAULT_CM, valid_out=0, obstacle_near=0, stale=0, stale counter 0, reject_count 0.
REQ-028 Reset SHALL override any in-flight pipeline stage; a strobe on the reset cycle SHALL be discarded and not counted.

Configuration
REQ-029 Macro SONAR_MEDIAN_EN defined: REQ-018..REQ-020 apply.
REQ-030 SONAR_MEDIAN_EN undefined: no window or FSM; distance_out = latest accepted sample, same two-cycle latency and valid_out timing.

Structure
REQ-031 Shared package sonar_pkg SHALL hold fill-state encoding and constants DIST_W=16, REJ_W=8.
REQ-032 Median-of-three SHALL be a combinational sub-module median3 (three 16-bit inputs, one output).

Verification
REQ-033 Reset, then samples 30,10,50 -> distance_out 30,10,30 each two cycles after strobe; valid_out single-cycle pulses.
REQ-034 Samples 0,1,400,65535 -> all rejected, reject_count=4, distance_out stays 25; 300 rejects -> reject_count=255.
REQ-035 FULL window 50,50,50 then 15 -> median 50, obstacle_near 0; then 15 -> 15, near=1; then 22,22,22 -> near stays 1; 25,25,25 -> near=0.
REQ-036 No strobe for 12_500_000 cycles -> stale=1 and obstacle_near=1; accept 100 -> stale=0 next cycle.
REQ-037 Strobes on 3 consecutive cycles with 40,60,20 -> three valid_out pulses on consecutive cycles, values 40,40,40.
REQ-038 reset_n low mid-pipeline with strobe present -> no valid_out, outputs at reset values; repeat with SONAR_MEDIAN_EN undefined -> 30,10,50 passed through unfiltered.

Source files
------------

// File: rtl/sonar_pkg.sv
// Shared types and widths for the sonar distance filter.
package sonar_pkg;

    localparam int unsigned DIST_W = 16;
    localparam int unsigned REJ_W  = 8;

    // Fill level of the 3-entry median window
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2,
        StFull  = 2'd3
    } fill_state_e;

endpackage

// File: rtl/median3.sv
// Combinational median of three unsigned distances.
// Only built with SONAR_MEDIAN_EN, since only the windowed filter uses it.
`ifdef SONAR_MEDIAN_EN
module median3
    import sonar_pkg::*;
(
    input  logic [DIST_W-1:0] a_i,
    input  logic [DIST_W-1:0] b_i,
    input  logic [DIST_W-1:0] c_i,
    output logic [DIST_W-1:0] med_o
);

    logic [DIST_W-1:0] lo_ab;
    logic [DIST_W-1:0] hi_ab;
    logic [DIST_W-1:0] lo_hc;

    // median = max(min(a,b), min(max(a,b),c))
    always_comb begin
        lo_ab = (a_i < b_i) ? a_i : b_i;
        hi_ab = (a_i < b_i) ? b_i : a_i;
        lo_hc = (hi_ab < c_i) ? hi_ab : c_i;
        med_o = (lo_ab > lo_hc) ? lo_ab : lo_hc;
    end

endmodule
`endif

// File: rtl/sonar_distance_filter.sv
// Range-gates raw sonar samples, filters them and flags near obstacles / stale data.
// Define SONAR_MEDIAN_EN for the 3-sample median window; otherwise samples pass through.
module sonar_distance_filter
    import sonar_pkg::*;
#(
    parameter int unsigned MIN_CM         = 2,
    parameter int unsigned MAX_CM         = 399,
    parameter int unsigned DEFAULT_CM     = 25,
    parameter int unsigned NEAR_CM        = 20,
    parameter int unsigned HYST_CM        = 5,
    parameter int unsigned TIMEOUT_CYCLES = 12_500_000
) (
    input  logic              clk_125mhz,
    input  logic              reset_n,
    input  logic [DIST_W-1:0] distance_cm,
    input  logic              measurement_ready,
    output logic [DIST_W-1:0] distance_out,
    output logic              valid_out,
    output logic              obstacle_near,
    output logic              stale,
    output logic [REJ_W-1:0]  reject_count
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [DIST_W-1:0] MinCm     = DIST_W'(MIN_CM);
    localparam logic [DIST_W-1:0] MaxCm     = DIST_W'(MAX_CM);
    localparam logic [DIST_W-1:0] DefaultCm = DIST_W'(DEFAULT_CM);
    localparam logic [DIST_W-1:0] NearCm    = DIST_W'(NEAR_CM);
    localparam logic [DIST_W-1:0] ReleaseCm = DIST_W'(NEAR_CM + HYST_CM);
    localparam logic [CntW-1:0]   StaleTerm = CntW'(TIMEOUT_CYCLES - 1);

    logic              accept;
    logic              reject;
    logic [DIST_W-1:0] filt;

    assign accept = measurement_ready && (distance_cm >= MinCm) && (distance_cm <= MaxCm);
    assign reject = measurement_ready && !accept;

`ifdef SONAR_MEDIAN_EN
    fill_state_e       state_q;
    fill_state_e       state_d;
    logic [DIST_W-1:0] win_q [3];
    logic [DIST_W-1:0] med;

    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                StEmpty: state_d = StOne;
                StOne:   state_d = StTwo;
                StTwo:   state_d = StFull;
                StFull:  state_d = StFull;
            endcase
        end
    end

    always_ff @(posedge clk_125mhz) begin
        if (!reset_n) begin
            state_q <= StEmpty;
            win_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            if (accept) begin
                win_q[2] <= win_q[1];
                win_q[1] <= win_q[0];
                win_q[0] <= distance_cm;
            end
        end
    end

    median3 u_median3 (
        .a_i   (win_q[0]),
        .b_i   (win_q[1]),
        .c_i   (win_q[2]),
        .med_o (med)
    );

    // Two samples: report the nearer one so the robot errs towards stopping
    always_comb begin
        filt = win_q[0];
        case (state_q)
            StTwo:   filt = (win_q[0] < win_q[1]) ? win_q[0] : win_q[1];
            StFull:  filt = med;
            default: filt = win_q[0];
        endcase
    end
`else
    logic [DIST_W-1:0] latest_q;

    always_ff @(posedge clk_125mhz) begin
        if (!reset_n) begin
            latest_q <= '0;
        end else if (accept) begin
            latest_q <= distance_cm;
        end
    end

    assign filt = latest_q;
`endif

    logic              pend_q;
    logic [DIST_W-1:0] dist_q;
    logic              valid_q;
    logic              near_q;
    logic [CntW-1:0]   stale_cnt_q;
    logic [REJ_W-1:0]  rej_q;

    // Second stage: publish the value the first stage captured on the previous cycle
    always_ff @(posedge clk_125mhz) begin
        if (!reset_n) begin
            pend_q      <= 1'b0;
            dist_q      <= DefaultCm;
            valid_q     <= 1'b0;
            near_q      <= 1'b0;
            stale_cnt_q <= '0;
            rej_q       <= '0;
        end else begin
            pend_q  <= accept;
            valid_q <= pend_q;
            if (pend_q) begin
                dist_q <= filt;
                if (filt < NearCm) begin
                    near_q <= 1'b1;
                end else if (filt >= ReleaseCm) begin
                    near_q <= 1'b0;
                end
            end
            if (accept) begin
                stale_cnt_q <= '0;
            end else if (stale_cnt_q != StaleTerm) begin
                stale_cnt_q <= stale_cnt_q + CntW'(1);
            end
            if (reject && (rej_q != '1)) begin
                rej_q <= rej_q + REJ_W'(1);
            end
        end
    end

    assign stale         = (stale_cnt_q == StaleTerm);
    assign distance_out  = dist_q;
    assign valid_out     = valid_q;
    assign obstacle_near = near_q | stale;
    assign reject_count  = rej_q;

endmodule
